// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store controller in front of mem's LSU
//            port, with alignment checks and a programmable access latency.
// Revision : 1.0
// ============================================================================
module lsu_ctrl #(
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] lsu_addr,
    output logic        lsu_wen,
    output logic [31:0] lsu_wdata,
    output logic [3:0]  lsu_wmask,
    input  logic [31:0] lsu_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] c_lat_m1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_req_err;

    function automatic logic f_err(input logic st, input logic [2:0] f3,
                                   input logic [1:0] off);
        logic ill;
        logic mis;
        ill = st ? (f3[2] || (f3 == 3'b011))
                 : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        mis = ((f3[1:0] == 2'b01) && off[0]) ||
              ((f3[1:0] == 2'b10) && (off != 2'b00));
        return ill || mis;
    endfunction

    function automatic logic [31:0] f_lane_data(input logic [2:0] f3,
                                                input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] f_lane_mask(input logic [2:0] f3,
                                               input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    assign w_req_err = f_err(req_store, req_funct3, req_addr[1:0]);

    // Bring the addressed byte/half down to bit 0, then extend per funct3.
    always_comb begin
        w_shift = lsu_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_store   <= 1'b0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_wdata   <= 32'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lsu_addr  <= RESET_ADDR;
            lsu_wen   <= 1'b0;
            lsu_wdata <= 32'd0;
            lsu_wmask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store   <= req_store;
                        r_funct3  <= req_funct3;
                        r_off     <= req_addr[1:0];
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        lsu_addr  <= {req_addr[31:2], 2'b00};
                        if (w_req_err) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (LATENCY == 0) begin
                            r_state <= S_ACCESS;
                            if (req_store) begin
                                lsu_wen   <= 1'b1;
                                lsu_wdata <= f_lane_data(req_funct3, req_wdata);
                                lsu_wmask <= f_lane_mask(req_funct3, req_addr[1:0]);
                            end
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_lat_m1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                        if (r_store) begin
                            lsu_wen   <= 1'b1;
                            lsu_wdata <= f_lane_data(r_funct3, r_wdata);
                            lsu_wmask <= f_lane_mask(r_funct3, r_off);
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    // mem performs the write on this edge; loads sample its read port.
                    lsu_wen   <= 1'b0;
                    lsu_wdata <= 32'd0;
                    lsu_wmask <= 4'd0;
                    rsp_rdata <= r_store ? 32'd0 : w_load;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl with a small word memory.
// Revision : 1.0
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] lsu_rdata;

    int n_tests;
    int n_fail;

    int          g_wen_cnt;
    int          g_wen_cyc;
    int          g_rsp_cyc;
    logic [31:0] g_wdata;
    logic [3:0]  g_wmask;
    logic [31:0] g_waddr;
    logic [31:0] g_rdata;
    logic        g_err;

    lsu_ctrl #(.LATENCY(2), .RESET_ADDR(32'h8000_0000)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .lsu_addr   (lsu_addr),
        .lsu_wen    (lsu_wen),
        .lsu_wdata  (lsu_wdata),
        .lsu_wmask  (lsu_wmask),
        .lsu_rdata  (lsu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-word memory with byte-masked writes and combinational read.
    logic [31:0] mem [0:15];
    assign lsu_rdata = mem[lsu_addr[5:2]];
    always @(posedge clk) begin
        if (lsu_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu_wmask[i]) mem[lsu_addr[5:2]][8*i +: 8] <= lsu_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issues one request and returns once rsp_valid is seen (handshake not yet taken).
    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_ready_pre", req_ready, 1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g_wen_cnt = 0; g_wen_cyc = 0; g_rsp_cyc = 0;
        g_wdata = '0; g_wmask = '0; g_waddr = '0; g_rdata = '0; g_err = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (lsu_wen) begin
                g_wen_cnt++;
                g_wen_cyc = c;
                g_wdata = lsu_wdata;
                g_wmask = lsu_wmask;
                g_waddr = lsu_addr;
            end
            if (rsp_valid) begin
                g_rsp_cyc = c;
                g_rdata = rsp_rdata;
                g_err = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (g_rsp_cyc == 0) check("rsp_timeout", 0, 1);
    endtask

    // Lets the response handshake edge pass with rsp_ready high.
    task automatic rsp_done();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after", req_ready, 1);
        check("rsp_valid_after", rsp_valid, 0);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        do_req(1'b0, f3, a, 32'd0);
        check(tag, g_rdata, exp);
        check({tag, "_err"}, g_err, 0);
        check({tag, "_wen"}, g_wen_cnt, 0);
        rsp_done();
    endtask

    initial begin
        int wen_seen;
        n_tests = 0; n_fail = 0;
        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err",   rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_lsu_wen",   lsu_wen, 0);
        check("rst_lsu_wmask", lsu_wmask, 0);
        check("rst_lsu_wdata", lsu_wdata, 0);
        check("rst_lsu_addr",  lsu_addr, 32'h8000_0000);
        rst = 1'b1;
        @(posedge clk); #1;

        // sw timing and lanes
        do_req(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
        check("sw_wen_cnt", g_wen_cnt, 1);
        check("sw_wen_cyc", g_wen_cyc, 3);
        check("sw_wmask",   g_wmask, 4'b1111);
        check("sw_wdata",   g_wdata, 32'hDEAD_BEEF);
        check("sw_addr",    g_waddr, 32'h8000_0010);
        check("sw_rsp_cyc", g_rsp_cyc, 4);
        check("sw_err",     g_err, 0);
        check("sw_rdata",   g_rdata, 0);
        rsp_done();

        // sb to the top byte lane
        do_req(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5);
        check("sb_wen_cnt", g_wen_cnt, 1);
        check("sb_wdata",   g_wdata, 32'hA5A5_A5A5);
        check("sb_wmask",   g_wmask, 4'b1000);
        check("sb_addr",    g_waddr, 32'h8000_0010);
        rsp_done();
        load_chk("lw_after_sb", 3'b010, 32'h8000_0010, 32'hA5AD_BEEF);

        // sh to upper half
        do_req(1'b1, 3'b001, 32'h8000_0012, 32'h0000_80F1);
        check("sh_wdata", g_wdata, 32'h80F1_80F1);
        check("sh_wmask", g_wmask, 4'b1100);
        rsp_done();
        do_req(1'b1, 3'b001, 32'h8000_0010, 32'h0000_1234);
        check("sh0_wmask", g_wmask, 4'b0011);
        rsp_done();

        // loads with memory word 0x80F1_1234
        load_chk("lw",  3'b010, 32'h8000_0010, 32'h80F1_1234);
        load_chk("lb",  3'b000, 32'h8000_0012, 32'hFFFF_FFF1);
        load_chk("lbu", 3'b100, 32'h8000_0012, 32'h0000_00F1);
        load_chk("lh",  3'b001, 32'h8000_0012, 32'hFFFF_80F1);
        load_chk("lhu", 3'b101, 32'h8000_0012, 32'h0000_80F1);
        load_chk("lb0", 3'b000, 32'h8000_0010, 32'h0000_0034);
        load_chk("lbu3", 3'b100, 32'h8000_0013, 32'h0000_0080);

        // error cases
        do_req(1'b0, 3'b010, 32'h8000_0006, 32'd0);
        check("mis_err", g_err, 1);
        check("mis_rdata", g_rdata, 0);
        check("mis_wen", g_wen_cnt, 0);
        check("mis_rsp_cyc", g_rsp_cyc, 1);
        rsp_done();
        do_req(1'b0, 3'b011, 32'h8000_0010, 32'd0);
        check("ill_err", g_err, 1);
        check("ill_rdata", g_rdata, 0);
        check("ill_rsp_cyc", g_rsp_cyc, 1);
        rsp_done();
        do_req(1'b1, 3'b100, 32'h8000_0010, 32'hFFFF_FFFF);
        check("st_ill_err", g_err, 1);
        check("st_ill_wen", g_wen_cnt, 0);
        rsp_done();
        do_req(1'b1, 3'b001, 32'h8000_0011, 32'hFFFF_FFFF);
        check("sh_mis_err", g_err, 1);
        check("sh_mis_wen", g_wen_cnt, 0);
        rsp_done();
        load_chk("lw_unchanged", 3'b010, 32'h8000_0010, 32'h80F1_1234);

        // response back-pressure
        rsp_ready = 1'b0;
        do_req(1'b0, 3'b101, 32'h8000_0012, 32'd0);
        check("hold_rdata0", g_rdata, 32'h0000_80F1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, 32'h0000_80F1);
            check("hold_lsu_addr",  lsu_addr, 32'h8000_0010);
            check("hold_req_ready", req_ready, 0);
            check("hold_lsu_wen",   lsu_wen, 0);
        end
        rsp_done();

        // reset during WAIT of a store
        do_req(1'b1, 3'b010, 32'h8000_0014, 32'h1111_1111);
        rsp_done();
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8000_0014; req_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_req_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_lsu_wen",   lsu_wen, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_lsu_addr",  lsu_addr, 32'h8000_0000);
        wen_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (lsu_wen) wen_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (lsu_wen) wen_seen++;
        end
        check("arst_no_wen", wen_seen, 0);
        load_chk("arst_word_kept", 3'b010, 32'h8000_0014, 32'h1111_1111);
        do_req(1'b1, 3'b010, 32'h8000_0014, 32'h3333_3333);
        check("post_rst_wen", g_wen_cnt, 1);
        check("post_rst_err", g_err, 0);
        rsp_done();
        load_chk("post_rst_word", 3'b010, 32'h8000_0014, 32'h3333_3333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting between the execute stage and the `mem` block's LSU port. Accepts one memory request at a time over a valid/ready handshake, checks alignment and encoding, and inserts a programmable wait to emulate memory latency. Drives word-aligned address, lane-shifted write data and byte mask into `mem`, then returns sign- or zero-extended load data over a response valid/ready handshake.

## Interface
- `LATENCY`, default 2: extra wait cycles before the memory access; legal range 0–15.
- `RESET_ADDR`, default 32'h8000_0000: value driven on `lsu_addr` out of reset, so `mem` never reads an unmapped address.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal funct3.
- `lsu_addr` out 32: to `mem`, always `{addr[31:2],2'b00}` of the latched request.
- `lsu_wen` out 1: to `mem`, write strobe.
- `lsu_wdata` out 32: to `mem`, lane-replicated store data.
- `lsu_wmask` out 4: to `mem`, byte enables.
- `lsu_rdata` in 32: from `mem`, combinational word read.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch store, funct3, addr and wdata. Also latch the error flag. Go to RESP if error, to ACCESS if `LATENCY`=0, otherwise to WAIT with the counter loaded to `LATENCY`-1.
- WAIT: decrement the counter each cycle. Go to ACCESS when the counter is 0.
- ACCESS: lasts exactly one cycle.
  - Store: `lsu_wen`=1, so `mem` writes on that edge.
  - Load: capture the shifted and extended `lsu_rdata` into `rsp_rdata`.
  - Then go to RESP.
- RESP: `rsp_valid`=1. Hold `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1, then go to IDLE.
- Error conditions:
  - Illegal funct3: loads with 011/110/111; stores with any funct3 other than 000/001/010.
  - Misaligned: h/hu with addr[0]=1; w with addr[1:0]≠0.
  - On error: no memory access, `lsu_wen` never asserts, `rsp_err`=1, `rsp_rdata`=0.
- Store lanes, with `off`=addr[1:0]:
  - sb: wdata={4{d[7:0]}}, wmask=4'b0001<<off.
  - sh: wdata={2{d[15:0]}}, wmask=4'b0011<<off.
  - sw: wdata=d, wmask=4'b1111.
- Load extraction: w = `lsu_rdata` >> (off×8).
  - b/bu: sign/zero extend w[7:0].
  - h/hu: sign/zero extend w[15:0].
  - w: the full word.
- `lsu_wen` is decoded from state (ACCESS && store) and is 0 in every other state. `lsu_wdata` and `lsu_wmask` are 0 outside ACCESS.
- Reset: all state returns to IDLE immediately, including mid-request. A pending store is dropped and no write occurs.
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `lsu_wen`=0, `lsu_wmask`=0, `lsu_wdata`=0.
  - `lsu_addr`=`RESET_ADDR`.

## Timing
- Request handshake at edge T. ACCESS occupies cycle T+1+`LATENCY`. `rsp_valid` rises in cycle T+2+`LATENCY`.
- Error request: `rsp_valid` rises in cycle T+1.
- `req_ready` is 0 from T+1 until the cycle after the response handshake. There is no back-to-back overlap: throughput is at most one request per `LATENCY`+3 cycles.
- Response handshake: the edge with `rsp_valid`&&`rsp_ready` returns the FSM to IDLE, and `req_ready`=1 in the next cycle.
- `rsp_ready` low holds RESP indefinitely with outputs unchanged and no further `mem` activity.
- `lsu_addr` changes only on request acceptance and is stable through WAIT, ACCESS and RESP.
- `lsu_wen` is high for exactly one cycle per legal store.

## Test plan
- sw 0xDEADBEEF to 0x8000_0010, `LATENCY`=2, `rsp_ready`=1.
  - `lsu_wen` is high for exactly one cycle, at T+3.
  - wmask=1111; `rsp_valid` in cycle T+4 with `rsp_err`=0.
- sb 0x000000A5 to 0x8000_0013.
  - wdata=0xA5A5A5A5, wmask=1000, `lsu_addr`=0x8000_0010.
- Loads at 0x8000_0012 with memory word 0x80F1_1234:
  - lb → 0xFFFF_FFF1
  - lbu → 0x0000_00F1
  - lh → 0xFFFF_80F1
  - lhu → 0x0000_80F1
- lw at 0x8000_0006 → `rsp_err`=1, `rsp_rdata`=0, `lsu_wen` never asserted, `rsp_valid` in cycle T+1. Repeat with load funct3=011 → same result.
- Hold `rsp_ready`=0 for 5 cycles after a load → `rsp_valid`, `rsp_rdata` and `lsu_addr` stable, `req_ready`=0. Release → `req_ready`=1 in the next cycle.
- Assert `rst` low during WAIT of an sw → immediate IDLE, `lsu_wen` stays 0, target word unchanged. The next request completes normally.
